// File: rtl/axis_cpu_defs.sv
// Shared axis_cpu BPF encoding constants: instruction classes, addressing modes,
// jump types, RET sources and regfile input selects.
package axis_cpu_defs;

  localparam logic [2:0] BPF_LD   = 3'h0;
  localparam logic [2:0] BPF_LDX  = 3'h1;
  localparam logic [2:0] BPF_ST   = 3'h2;
  localparam logic [2:0] BPF_STX  = 3'h3;
  localparam logic [2:0] BPF_ALU  = 3'h4;
  localparam logic [2:0] BPF_JMP  = 3'h5;
  localparam logic [2:0] BPF_RET  = 3'h6;
  localparam logic [2:0] BPF_MISC = 3'h7;

  localparam logic [2:0] BPF_ABS  = 3'h1;
  localparam logic [2:0] BPF_IND  = 3'h2;
  localparam logic [2:0] BPF_MEM  = 3'h3;
  localparam logic [2:0] BPF_MSH  = 3'h5;

  localparam logic [3:0] BPF_JA   = 4'h0;

  localparam logic [1:0] BPF_RVAL_X = 2'h1;
  localparam logic [1:0] BPF_RVAL_A = 2'h2;

  localparam logic [4:0] BPF_MISC_TAX = 5'h00;
  localparam logic [4:0] BPF_MISC_TXA = 5'h10;

  localparam logic REGFILE_IN_A = 1'b0;
  localparam logic REGFILE_IN_X = 1'b1;

endpackage

// File: rtl/bpf_decode_stage_pkg.sv
// Decode-stage types: the hazard class carried with each buffered instruction
// and the helper that derives it from the opcode.
package bpf_decode_stage_pkg;
  import axis_cpu_defs::*;

  localparam int INSTR_W = 64;

  typedef struct packed {
    logic writes_A;
    logic writes_X;
    logic reads_regfile;
  } haz_class_t;

  localparam int HAZ_CLASS_W = $bits(haz_class_t);

  function automatic haz_class_t write_class(input logic [7:0] opc);
    haz_class_t c;
    logic [2:0] cls;
    logic [2:0] mode;
    cls  = opc[2:0];
    mode = opc[7:5];
    c.writes_A      = (cls == BPF_LD) || (cls == BPF_ALU) ||
                      ((cls == BPF_MISC) && (opc[7:3] == BPF_MISC_TXA));
    c.writes_X      = (cls == BPF_LDX) ||
                      ((cls == BPF_MISC) && (opc[7:3] == BPF_MISC_TAX));
    c.reads_regfile = ((cls == BPF_LD) || (cls == BPF_LDX)) && (mode == BPF_MEM);
    return c;
  endfunction

endpackage

// File: rtl/bpf_decode_stage_if.sv
// Fetch-side, hazard and downstream signals of the decode stage; the stage
// itself connects through the slave modport.
interface bpf_decode_stage_if #(
  parameter int NUM_HAZ_STAGES = 1,
  parameter int COUNT_WIDTH    = 6
);
  logic [63:0]               instr_in;
  logic                      prev_vld;
  logic                      rdy;
  logic                      branch_mispredict;
  logic                      PC_en;
  logic [COUNT_WIDTH-1:0]    icount;
  logic [NUM_HAZ_STAGES-1:0] haz_writes_A;
  logic [NUM_HAZ_STAGES-1:0] haz_writes_X;
  logic [NUM_HAZ_STAGES-1:0] haz_reads_regfile;
  logic                      B_sel;
  logic [3:0]                ALU_sel;
  logic                      ALU_en;
  logic                      rd_en;
  logic                      regfile_wr_en;
  logic                      regfile_sel_stage1;
  logic [31:0]               imm_stage1;
  logic [63:0]               instr_out;
  logic [COUNT_WIDTH-1:0]    ocount;
  logic                      o_writes_A;
  logic                      o_writes_X;
  logic                      o_reads_regfile;
  logic                      vld;
  logic                      next_rdy;
  logic [15:0]               stall_cycles;

  modport slave (
    input  instr_in, prev_vld, branch_mispredict, PC_en, icount,
           haz_writes_A, haz_writes_X, haz_reads_regfile, next_rdy,
    output rdy, B_sel, ALU_sel, ALU_en, rd_en, regfile_wr_en,
           regfile_sel_stage1, imm_stage1, instr_out, ocount,
           o_writes_A, o_writes_X, o_reads_regfile, vld, stall_cycles
  );

  modport master (
    output instr_in, prev_vld, branch_mispredict, PC_en, icount,
           haz_writes_A, haz_writes_X, haz_reads_regfile, next_rdy,
    input  rdy, B_sel, ALU_sel, ALU_en, rd_en, regfile_wr_en,
           regfile_sel_stage1, imm_stage1, instr_out, ocount,
           o_writes_A, o_writes_X, o_reads_regfile, vld, stall_cycles
  );

endinterface

// File: rtl/bpf_decode_stage_bhand_fifo_count.sv
// Handshake circular buffer whose entries carry a saturating cycle count that
// advances on every PC_en cycle; outputs read as zero while empty.
module bhand_fifo_count #(
  parameter int DEPTH       = 2,
  parameter int DATA_W      = 67,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_pc_en,
  input  logic [DATA_W-1:0]      i_data,
  input  logic [COUNT_WIDTH-1:0] i_count,
  output logic [DATA_W-1:0]      o_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_vld,
  output logic                   o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  logic [DATA_W-1:0]      r_data [DEPTH];
  logic [COUNT_WIDTH-1:0] r_cnt  [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [OCC_W-1:0]       r_occ;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_push  = i_push & ~w_full & ~i_flush;
  assign w_pop   = i_pop & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_data[r_wr_ptr] <= i_data;
  end

  // Stale slots also tick; they are overwritten on their next push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (r_wr_ptr == PTR_W'(i)))
        r_cnt[i] <= i_pc_en ? sat_inc(i_count) : i_count;
      else if (i_pc_en)
        r_cnt[i] <= sat_inc(r_cnt[i]);
    end
  end

  assign o_vld   = ~w_empty;
  assign o_full  = w_full;
  assign o_data  = w_empty ? '0 : r_data[r_rd_ptr];
  assign o_count = w_empty ? '0 : r_cnt[r_rd_ptr];

endmodule

// File: rtl/bpf_decode_stage.sv
// BPF decode stage: stage-1 control decode, A/X/regfile hazard stall and a
// counted instruction buffer. Optional DECODE_STALL_STATS_EN adds a stall counter.
module bpf_decode_stage
  import axis_cpu_defs::*;
  import bpf_decode_stage_pkg::*;
#(
  parameter int NUM_HAZ_STAGES = 1,
  parameter int BUF_DEPTH      = 2,
  parameter int COUNT_WIDTH    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  bpf_decode_stage_if.slave  bus
);

  localparam int ENTRY_W = INSTR_W + HAZ_CLASS_W;

  logic [7:0] w_opc;
  logic [2:0] w_cls;
  logic [2:0] w_mode;
  logic       w_is_ld, w_is_ldx, w_is_st, w_is_stx;
  logic       w_is_alu, w_is_jmp, w_is_ret, w_is_misc;
  logic       w_mode_abs, w_mode_ind, w_mode_msh;

  assign w_opc      = bus.instr_in[55:48];
  assign w_cls      = w_opc[2:0];
  assign w_mode     = w_opc[7:5];
  assign w_is_ld    = (w_cls == BPF_LD);
  assign w_is_ldx   = (w_cls == BPF_LDX);
  assign w_is_st    = (w_cls == BPF_ST);
  assign w_is_stx   = (w_cls == BPF_STX);
  assign w_is_alu   = (w_cls == BPF_ALU);
  assign w_is_jmp   = (w_cls == BPF_JMP);
  assign w_is_ret   = (w_cls == BPF_RET);
  assign w_is_misc  = (w_cls == BPF_MISC);
  assign w_mode_abs = (w_mode == BPF_ABS);
  assign w_mode_ind = (w_mode == BPF_IND);
  assign w_mode_msh = (w_mode == BPF_MSH);

  logic w_alu_en_dec, w_rd_en_dec, w_wr_en_dec;
  logic w_reads_A, w_reads_X;

  assign w_alu_en_dec = w_is_alu | (w_is_jmp & (w_opc[7:4] != BPF_JA));
  assign w_rd_en_dec  = (w_is_ld  & (w_mode_abs | w_mode_ind)) |
                        (w_is_ldx & (w_mode_abs | w_mode_ind | w_mode_msh));
  assign w_wr_en_dec  = w_is_st | w_is_stx;

  assign w_reads_A = w_is_alu | w_is_jmp | w_is_st |
                     (w_is_ret  & (w_opc[4:3] == BPF_RVAL_A)) |
                     (w_is_misc & (w_opc[7:3] == BPF_MISC_TAX));
  assign w_reads_X = ((w_is_ld | w_is_ldx) & w_mode_ind) | w_is_stx |
                     (w_is_ret  & (w_opc[4:3] == BPF_RVAL_X)) |
                     (w_is_misc & (w_opc[7:3] == BPF_MISC_TXA));

  logic [NUM_HAZ_STAGES-1:0] w_haz_a, w_haz_x, w_haz_rf;
  logic                      w_stalled;
  logic                      w_full;
  logic                      w_rdy;
  logic                      w_accept;

  assign w_haz_a  = bus.haz_writes_A;
  assign w_haz_x  = bus.haz_writes_X;
  assign w_haz_rf = bus.haz_reads_regfile;

  assign w_stalled = (w_reads_A   & (|w_haz_a)) |
                     (w_reads_X   & (|w_haz_x)) |
                     (w_wr_en_dec & (|w_haz_rf));

  // rdy never depends on next_rdy: a full buffer blocks input even if it pops.
  assign w_rdy    = rst_n & ~w_full & ~w_stalled & ~bus.branch_mispredict;
  assign w_accept = bus.prev_vld & w_rdy;

  assign bus.rdy                = w_rdy;
  assign bus.B_sel              = w_opc[3];
  assign bus.ALU_sel            = w_opc[7:4];
  assign bus.imm_stage1         = bus.instr_in[31:0];
  assign bus.regfile_sel_stage1 = w_is_stx ? REGFILE_IN_X : REGFILE_IN_A;
  assign bus.ALU_en             = w_alu_en_dec & w_accept;
  assign bus.rd_en              = w_rd_en_dec  & w_accept;
  assign bus.regfile_wr_en      = w_wr_en_dec  & w_accept;

  haz_class_t                w_in_class;
  haz_class_t                w_head_class;
  logic [ENTRY_W-1:0]        w_head;
  logic [COUNT_WIDTH-1:0]    w_head_count;
  logic                      w_vld;

  assign w_in_class = write_class(w_opc);

  bhand_fifo_count #(
    .DEPTH       (BUF_DEPTH),
    .DATA_W      (ENTRY_W),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.branch_mispredict),
    .i_push  (w_accept),
    .i_pop   (w_vld & bus.next_rdy),
    .i_pc_en (bus.PC_en),
    .i_data  ({w_in_class, bus.instr_in}),
    .i_count (bus.icount),
    .o_data  (w_head),
    .o_count (w_head_count),
    .o_vld   (w_vld),
    .o_full  (w_full)
  );

  // The buffer zeroes its head while empty, so these are 0 whenever vld is 0.
  assign w_head_class        = haz_class_t'(w_head[ENTRY_W-1:INSTR_W]);
  assign bus.instr_out       = w_head[INSTR_W-1:0];
  assign bus.ocount          = w_head_count;
  assign bus.vld             = w_vld;
  assign bus.o_writes_A      = w_head_class.writes_A;
  assign bus.o_writes_X      = w_head_class.writes_X;
  assign bus.o_reads_regfile = w_head_class.reads_regfile;

`ifdef DECODE_STALL_STATS_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (bus.prev_vld & w_stalled & ~bus.branch_mispredict & (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_bpf_decode_stage.sv
// Directed bench for bpf_decode_stage with a scoreboard of buffered entries
// that is checked against the head of the buffer every cycle.
module tb_bpf_decode_stage;

  localparam int DEPTH = 2;
  localparam int CW    = 6;
  localparam int NH    = 2;

`ifdef DECODE_STALL_STATS_EN
  localparam logic [15:0] EXP_STALLS = 16'd3;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic exp_stall;
  logic m_rdy;

  typedef struct packed {
    logic [63:0]   instr;
    logic [CW-1:0] cnt;
    logic          wa;
    logic          wx;
    logic          rr;
  } ent_t;

  ent_t sbq[$];

  bpf_decode_stage_if #(.NUM_HAZ_STAGES(NH), .COUNT_WIDTH(CW)) bus ();

  bpf_decode_stage #(
    .NUM_HAZ_STAGES (NH),
    .BUF_DEPTH      (DEPTH),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [7:0] opc, input logic [31:0] imm);
    return {8'h00, opc, 8'h11, 8'h22, imm};
  endfunction

  function automatic logic [CW-1:0] tsat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  function automatic logic cls_wa(input logic [7:0] o);
    return (o[2:0] == 3'd0) || (o[2:0] == 3'd4) || ((o[2:0] == 3'd7) && (o[7:3] == 5'h10));
  endfunction
  function automatic logic cls_wx(input logic [7:0] o);
    return (o[2:0] == 3'd1) || ((o[2:0] == 3'd7) && (o[7:3] == 5'h00));
  endfunction
  function automatic logic cls_rr(input logic [7:0] o);
    return ((o[2:0] == 3'd0) || (o[2:0] == 3'd1)) && (o[7:5] == 3'd3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the head, then model the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
    end else begin
      m_rdy = (sbq.size() < DEPTH) && !exp_stall && !bus.branch_mispredict;
      chk("sb_rdy", 64'(bus.rdy), 64'(m_rdy));
      chk("sb_vld", 64'(bus.vld), 64'(sbq.size() != 0));
      if (sbq.size() != 0) begin
        chk("sb_instr_out", bus.instr_out, sbq[0].instr);
        chk("sb_ocount", 64'(bus.ocount), 64'(sbq[0].cnt));
        chk("sb_class", 64'({bus.o_writes_A, bus.o_writes_X, bus.o_reads_regfile}),
            64'({sbq[0].wa, sbq[0].wx, sbq[0].rr}));
      end else begin
        chk("sb_empty_out", bus.instr_out, 64'd0);
        chk("sb_empty_class", 64'({bus.o_writes_A, bus.o_writes_X, bus.o_reads_regfile}), 64'd0);
      end
      if ((sbq.size() != 0) && bus.next_rdy) sbq.delete(0);
      if (bus.branch_mispredict) sbq.delete();
      if (bus.PC_en) foreach (sbq[i]) sbq[i].cnt = tsat(sbq[i].cnt);
      if (bus.prev_vld && m_rdy)
        sbq.push_back('{instr: bus.instr_in,
                        cnt:   bus.PC_en ? tsat(bus.icount) : bus.icount,
                        wa:    cls_wa(bus.instr_in[55:48]),
                        wx:    cls_wx(bus.instr_in[55:48]),
                        rr:    cls_rr(bus.instr_in[55:48])});
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    exp_stall = 1'b0;
    rst_n = 1'b0;
    bus.instr_in = mk(8'h04, 32'h5);
    bus.prev_vld = 1'b1;
    bus.icount = '0;
    bus.PC_en = 1'b0;
    bus.branch_mispredict = 1'b0;
    bus.next_rdy = 1'b0;
    bus.haz_writes_A = '0;
    bus.haz_writes_X = '0;
    bus.haz_reads_regfile = '0;

    // Reset state
    #2;
    chk("rst_rdy", 64'(bus.rdy), 64'd0);
    chk("rst_vld", 64'(bus.vld), 64'd0);
    chk("rst_instr_out", bus.instr_out, 64'd0);
    chk("rst_ocount", 64'(bus.ocount), 64'd0);
    chk("rst_class", 64'({bus.o_writes_A, bus.o_writes_X, bus.o_reads_regfile}), 64'd0);
    chk("rst_stall_cycles", 64'(bus.stall_cycles), 64'd0);
    chk("rst_alu_en", 64'(bus.ALU_en), 64'd0);
    bus.prev_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.next_rdy = 1'b1;
    #1 chk("post_rst_rdy", 64'(bus.rdy), 64'd1);

    // Four ALU ADD K back to back
    for (int k = 1; k <= 4; k++) begin
      bus.prev_vld = 1'b1;
      bus.instr_in = mk(8'h04, 32'(k));
      bus.icount = CW'(k * 2);
      #1;
      chk("alu_en", 64'(bus.ALU_en), 64'd1);
      chk("alu_imm", 64'(bus.imm_stage1), 64'(k));
      chk("alu_rd_en", 64'(bus.rd_en), 64'd0);
      chk("alu_vld", 64'(bus.vld), 64'(k > 1));
      cyc();
    end
    bus.prev_vld = 1'b0;
    #1;
    chk("alu_en_off", 64'(bus.ALU_en), 64'd0);
    chk("alu_last_vld", 64'(bus.vld), 64'd1);
    cyc();
    chk("alu_drained", 64'(bus.vld), 64'd0);

    // LD ABS does not read A, so an A-writer downstream does not hold it
    bus.prev_vld = 1'b1;
    bus.instr_in = mk(8'h20, 32'h40);
    bus.haz_writes_A = 2'b10;
    #1;
    chk("ldabs_rdy", 64'(bus.rdy), 64'd1);
    chk("ldabs_rd_en", 64'(bus.rd_en), 64'd1);
    cyc();
    bus.haz_writes_A = '0;

    // LD IND reads X: stalls while stage 3 writes X
    bus.instr_in = mk(8'h40, 32'h8);
    bus.haz_writes_X = 2'b10;
    exp_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ldind_stall_rdy", 64'(bus.rdy), 64'd0);
      chk("ldind_stall_rd_en", 64'(bus.rd_en), 64'd0);
      cyc();
    end
    bus.haz_writes_X = '0;
    exp_stall = 1'b0;
    #1;
    chk("ldind_rdy", 64'(bus.rdy), 64'd1);
    chk("ldind_rd_en", 64'(bus.rd_en), 64'd1);
    cyc();
    bus.prev_vld = 1'b0;
    #1 chk("stall_cycles", 64'(bus.stall_cycles), 64'(EXP_STALLS));
    cyc();

    // Fill with next_rdy low, then age entries with PC_en
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    bus.instr_in = mk(8'h04, 32'h10);
    bus.icount = 6'd10;
    #1 chk("fill0_rdy", 64'(bus.rdy), 64'd1);
    cyc();
    bus.instr_in = mk(8'h04, 32'h60);
    bus.icount = 6'd60;
    #1 chk("fill1_rdy", 64'(bus.rdy), 64'd1);
    cyc();
    bus.instr_in = mk(8'h04, 32'h99);
    #1;
    chk("full_rdy", 64'(bus.rdy), 64'd0);
    chk("full_alu_en", 64'(bus.ALU_en), 64'd0);
    cyc();
    bus.prev_vld = 1'b0;
    bus.PC_en = 1'b1;
    repeat (5) cyc();
    bus.PC_en = 1'b0;
    bus.next_rdy = 1'b1;
    bus.prev_vld = 1'b1;
    #1;
    chk("age_ocount0", 64'(bus.ocount), 64'd15);
    chk("full_pop_rdy", 64'(bus.rdy), 64'd0);
    cyc();
    bus.prev_vld = 1'b0;
    #1 chk("age_ocount1_sat", 64'(bus.ocount), 64'd63);
    cyc();
    chk("age_drained", 64'(bus.vld), 64'd0);

    // Flush with two entries buffered
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    bus.instr_in = mk(8'h04, 32'hA1);
    cyc();
    bus.instr_in = mk(8'h04, 32'hA2);
    cyc();
    bus.instr_in = mk(8'h04, 32'hA3);
    bus.branch_mispredict = 1'b1;
    #1;
    chk("flush_alu_en", 64'(bus.ALU_en), 64'd0);
    chk("flush_rdy", 64'(bus.rdy), 64'd0);
    cyc();
    bus.branch_mispredict = 1'b0;
    bus.prev_vld = 1'b0;
    #1 chk("flush_vld", 64'(bus.vld), 64'd0);
    cyc();
    bus.branch_mispredict = 1'b1;
    bus.prev_vld = 1'b1;
    #1;
    chk("flush_empty_rdy", 64'(bus.rdy), 64'd0);
    chk("flush_empty_alu_en", 64'(bus.ALU_en), 64'd0);
    cyc();
    bus.branch_mispredict = 1'b0;
    bus.next_rdy = 1'b1;
    bus.instr_in = mk(8'h04, 32'hA4);
    #1;
    chk("post_flush_rdy", 64'(bus.rdy), 64'd1);
    chk("post_flush_alu_en", 64'(bus.ALU_en), 64'd1);
    cyc();
    bus.prev_vld = 1'b0;
    #1 chk("post_flush_head", bus.instr_out, mk(8'h04, 32'hA4));
    cyc();

    // STX behind a stage-2 regfile reader
    bus.prev_vld = 1'b1;
    bus.instr_in = mk(8'h03, 32'h2);
    bus.haz_reads_regfile = 2'b01;
    exp_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stx_stall_rdy", 64'(bus.rdy), 64'd0);
      chk("stx_stall_wr_en", 64'(bus.regfile_wr_en), 64'd0);
      cyc();
    end
    bus.haz_reads_regfile = '0;
    exp_stall = 1'b0;
    #1;
    chk("stx_sel", 64'(bus.regfile_sel_stage1), 64'd1);
    chk("stx_wr_en", 64'(bus.regfile_wr_en), 64'd1);
    cyc();
    bus.prev_vld = 1'b0;
    #1 chk("stx_wr_en_off", 64'(bus.regfile_wr_en), 64'd0);
    cyc();

    // Asynchronous reset with the buffer full
    bus.next_rdy = 1'b0;
    bus.prev_vld = 1'b1;
    bus.instr_in = mk(8'h04, 32'hB1);
    cyc();
    bus.instr_in = mk(8'h04, 32'hB2);
    cyc();
    bus.instr_in = mk(8'h04, 32'hB3);
    #1;
    chk("pre_rst_vld", 64'(bus.vld), 64'd1);
    chk("pre_rst_rdy", 64'(bus.rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.vld), 64'd0);
    chk("arst_rdy", 64'(bus.rdy), 64'd0);
    chk("arst_instr_out", bus.instr_out, 64'd0);
    chk("arst_ocount", 64'(bus.ocount), 64'd0);
    chk("arst_class", 64'({bus.o_writes_A, bus.o_writes_X, bus.o_reads_regfile}), 64'd0);
    chk("arst_hot", 64'({bus.ALU_en, bus.rd_en, bus.regfile_wr_en}), 64'd0);
    chk("arst_stall_cycles", 64'(bus.stall_cycles), 64'd0);
    bus.prev_vld = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_arst_vld", 64'(bus.vld), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
